// File: rtl/utils_pkg.sv
// Shared LSU types and the store lane-formatting helpers used by store_buf.
package utils_pkg;

    typedef enum logic [1:0] {
        LSU_B = 2'd0,
        LSU_H = 2'd1,
        LSU_W = 2'd2
    } lsu_w_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } s_st_entry_t;

    // Lanes that fall off the top of the word are dropped; an unknown width is handled as a word.
    function automatic s_st_entry_t fmt_store(input logic [31:0] addr, input lsu_w_t w,
                                              input logic [31:0] data);
        s_st_entry_t e;
        e.addr = {addr[31:2], 2'b00};
        case (w)
            LSU_B: begin
                e.data = data << {addr[1:0], 3'b000};
                e.strb = 4'b0001 << addr[1:0];
            end
            LSU_H: begin
                e.data = data << {addr[1:0], 3'b000};
                e.strb = 4'b0011 << addr[1:0];
            end
            default: begin
                e.data = data;
                e.strb = 4'b1111;
            end
        endcase
        return e;
    endfunction

    function automatic logic misaligned(input logic [1:0] off, input lsu_w_t w);
        logic m;
        case (w)
            LSU_B:   m = 1'b0;
            LSU_H:   m = off[0];
            default: m = |off;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fifo_sb.sv
// Circular store FIFO; also exposes the head as it will be after this cycle's
// push/pop so the consumer can register it with no bubble.
module fifo_sb
    import utils_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = s_st_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_din,
    input  logic i_pop,
    output T     o_head_nxt,
    output logic o_full,
    output logic o_empty,
    output logic o_empty_nxt
);
    localparam int AW = $clog2(DEPTH);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_cnt_nxt;
    logic [AW-1:0] w_rd1;

    assign o_full      = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty     = (r_cnt == '0);
    assign w_push      = i_push && (!o_full || i_pop);
    assign w_pop       = i_pop && !o_empty;
    assign w_cnt_nxt   = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign o_empty_nxt = (w_cnt_nxt == '0);
    assign w_rd1       = r_rd + AW'(1);

    always_comb begin
        o_head_nxt = r_mem[r_rd];
        if (w_pop) begin
            if (r_cnt > (AW+1)'(1))
                o_head_nxt = r_mem[w_rd1];
            else
                o_head_nxt = i_din;
        end else if (o_empty) begin
            o_head_nxt = i_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/store_buf.sv
// Store buffer: formats stores into byte lanes, queues them, and issues bus writes
// with an outstanding-response limit. STORE_BUF_MISALIGN_CHK_EN enables misaligned-store rejection.
module store_buf
    import utils_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int MAX_OT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid_i,
    output logic        st_ready_o,
    input  logic [31:0] st_addr_i,
    input  lsu_w_t      st_width_i,
    input  logic [31:0] st_data_i,
    output logic        wr_valid_o,
    input  logic        wr_ready_i,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_strb_o,
    input  logic        bresp_valid_i,
    input  logic        bresp_err_i,
    output logic        empty_o,
    output logic        st_err_o,
    output logic        st_misalign_o
);
    localparam int OW = $clog2(MAX_OT + 1);

    s_st_entry_t   w_entry;
    s_st_entry_t   w_head_nxt;
    s_st_entry_t   r_wr;
    logic          w_full;
    logic          w_fifo_empty;
    logic          w_empty_nxt;
    logic          w_acc;
    logic          w_push;
    logic          w_hs;
    logic          w_resp;
    logic [OW-1:0] r_ot;
    logic [OW-1:0] w_ot_nxt;
    logic          r_wr_valid;
    logic          r_st_err;

    assign w_entry    = fmt_store(st_addr_i, st_width_i, st_data_i);
    assign st_ready_o = !w_full;
    assign w_acc      = st_valid_i && st_ready_o;
    assign w_hs       = r_wr_valid && wr_ready_i;
    // Responses with nothing outstanding belong to stores dropped by reset.
    assign w_resp     = bresp_valid_i && (r_ot != '0);
    assign w_ot_nxt   = r_ot + OW'(w_hs) - OW'(w_resp);

`ifdef STORE_BUF_MISALIGN_CHK_EN
    logic w_mis;
    logic r_mis;

    assign w_mis  = misaligned(st_addr_i[1:0], st_width_i);
    assign w_push = w_acc && !w_mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_mis <= 1'b0;
        else      r_mis <= w_acc && w_mis;
    end

    assign st_misalign_o = r_mis;
`else
    assign w_push        = w_acc;
    assign st_misalign_o = 1'b0;
`endif

    fifo_sb #(
        .DEPTH (DEPTH),
        .T     (s_st_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_din       (w_entry),
        .i_pop       (w_hs),
        .o_head_nxt  (w_head_nxt),
        .o_full      (w_full),
        .o_empty     (w_fifo_empty),
        .o_empty_nxt (w_empty_nxt)
    );

    // The write port mirrors the post-update FIFO head, so it stays put while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ot       <= '0;
            r_wr_valid <= 1'b0;
            r_wr       <= '0;
            r_st_err   <= 1'b0;
        end else begin
            r_ot       <= w_ot_nxt;
            r_wr_valid <= !w_empty_nxt && (w_ot_nxt < OW'(MAX_OT));
            if (!w_empty_nxt) r_wr <= w_head_nxt;
            r_st_err   <= w_resp && bresp_err_i;
        end
    end

    assign wr_valid_o = r_wr_valid;
    assign wr_addr_o  = r_wr.addr;
    assign wr_data_o  = r_wr.data;
    assign wr_strb_o  = r_wr.strb;
    assign st_err_o   = r_st_err;
    assign empty_o    = w_fifo_empty && (r_ot == '0);

endmodule

// File: tb/tb_store_buf.sv
// Directed bench for store_buf: scoreboard of expected bus writes, immediate assertions.
module tb_store_buf;
    import utils_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_valid_i = 1'b0;
    logic        st_ready_o;
    logic [31:0] st_addr_i = '0;
    lsu_w_t      st_width_i = LSU_B;
    logic [31:0] st_data_i = '0;
    logic        wr_valid_o;
    logic        wr_ready_i = 1'b0;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_strb_o;
    logic        bresp_valid_i = 1'b0;
    logic        bresp_err_i = 1'b0;
    logic        empty_o;
    logic        st_err_o;
    logic        st_misalign_o;

    s_st_entry_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_buf dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid_i    (st_valid_i),
        .st_ready_o    (st_ready_o),
        .st_addr_i     (st_addr_i),
        .st_width_i    (st_width_i),
        .st_data_i     (st_data_i),
        .wr_valid_o    (wr_valid_o),
        .wr_ready_i    (wr_ready_i),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .wr_strb_o     (wr_strb_o),
        .bresp_valid_i (bresp_valid_i),
        .bresp_err_i   (bresp_err_i),
        .empty_o       (empty_o),
        .st_err_o      (st_err_o),
        .st_misalign_o (st_misalign_o)
    );

    function automatic s_st_entry_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        s_st_entry_t e;
        e.addr = a;
        e.data = d;
        e.strb = s;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge; compares any write about to handshake, then advances one cycle.
    task automatic tick(output logic acc);
        s_st_entry_t e;
        #1;
        if (wr_valid_o && wr_ready_i) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL unexpected_write: observed addr %h expected no write", wr_addr_o);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", wr_addr_o, e.addr);
                chk("wr_data", wr_data_o, e.data);
                chk("wr_strb", 32'(wr_strb_o), 32'(e.strb));
            end
        end
        acc = st_valid_i && st_ready_o;
        @(negedge clk);
        if (acc) st_valid_i = 1'b0;
    endtask

    task automatic step();
        logic a;
        tick(a);
    endtask

    task automatic store(input logic [31:0] a, input lsu_w_t w, input logic [31:0] d,
                         input s_st_entry_t exp, input bit expect_write);
        logic acc;
        int   n;
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_width_i = w;
        st_data_i  = d;
        if (expect_write) sb.push_back(exp);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $error("FAIL store_timeout: observed not accepted expected accepted addr %h", a);
            st_valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        wr_ready_i = 1'b1;
        while (sb.size() > 0 && n < 30) begin
            step();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic resp(input bit err);
        bresp_valid_i = 1'b1;
        bresp_err_i   = err;
        step();
        bresp_valid_i = 1'b0;
        bresp_err_i   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_valid"}, 32'(wr_valid_o), 32'd0);
        chk({tag, "_wr_addr"}, wr_addr_o, 32'd0);
        chk({tag, "_wr_data"}, wr_data_o, 32'd0);
        chk({tag, "_wr_strb"}, 32'(wr_strb_o), 32'd0);
        chk({tag, "_st_err"}, 32'(st_err_o), 32'd0);
        chk({tag, "_misalign"}, 32'(st_misalign_o), 32'd0);
        chk({tag, "_empty"}, 32'(empty_o), 32'd1);
        chk({tag, "_ready"}, 32'(st_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b1;
        step();

        // Byte store into the top lane, first-write latency
        wr_ready_i = 1'b1;
        store(32'h1003, LSU_B, 32'hAB, mk(32'h1000, 32'hAB000000, 4'b1000), 1);
        chk("latency_valid", 32'(wr_valid_o), 32'd1);
        drain();
        chk("ot1_not_empty", 32'(empty_o), 32'd0);
        resp(0);
        chk("ot0_empty", 32'(empty_o), 32'd1);
        chk("no_err", 32'(st_err_o), 32'd0);

        // Half, word and byte formatting, streamed back-to-back
        store(32'h2002, LSU_H, 32'h1234, mk(32'h2000, 32'h12340000, 4'b1100), 1);
        store(32'h2000, LSU_W, 32'hDEADBEEF, mk(32'h2000, 32'hDEADBEEF, 4'b1111), 1);
        store(32'h2001, LSU_B, 32'h55, mk(32'h2000, 32'h00005500, 4'b0010), 1);
        drain();
        wr_ready_i = 1'b0;
        resp(0);
        resp(0);
        chk("two_resp_not_empty", 32'(empty_o), 32'd0);
        resp(0);
        chk("three_resp_empty", 32'(empty_o), 32'd1);

        // Full FIFO with the bus stalled: third store waits, head held, order kept
        store(32'h5000, LSU_W, 32'hA0A0A0A0, mk(32'h5000, 32'hA0A0A0A0, 4'b1111), 1);
        store(32'h5004, LSU_W, 32'hB1B1B1B1, mk(32'h5004, 32'hB1B1B1B1, 4'b1111), 1);
        st_valid_i = 1'b1;
        st_addr_i  = 32'h5008;
        st_width_i = LSU_W;
        st_data_i  = 32'hC2C2C2C2;
        sb.push_back(mk(32'h5008, 32'hC2C2C2C2, 4'b1111));
        for (int i = 0; i < 2; i++) begin
            chk("full_ready_low", 32'(st_ready_o), 32'd0);
            chk("stall_valid", 32'(wr_valid_o), 32'd1);
            chk("stall_addr", wr_addr_o, 32'h5000);
            chk("stall_data", wr_data_o, 32'hA0A0A0A0);
            tick(acc);
        end
        wr_ready_i = 1'b1;
        tick(acc);
        chk("third_not_taken", 32'(acc), 32'd0);
        chk("ready_after_pop", 32'(st_ready_o), 32'd1);
        tick(acc);
        chk("third_taken", 32'(acc), 32'd1);
        drain();
        wr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) resp(0);
        chk("fifo_test_empty", 32'(empty_o), 32'd1);

        // Outstanding limit: fifth write held until one response
        wr_ready_i = 1'b1;
        for (int i = 0; i < 5; i++)
            store(32'h6000 + 32'(4 * i), LSU_W, 32'h60 + 32'(i),
                  mk(32'h6000 + 32'(4 * i), 32'h60 + 32'(i), 4'b1111), 1);
        for (int i = 0; i < 3; i++) begin
            chk("ot_cap_valid", 32'(wr_valid_o), 32'd0);
            step();
        end
        chk("ot_cap_pending", 32'(sb.size()), 32'd1);
        chk("ot_cap_not_empty", 32'(empty_o), 32'd0);
        resp(0);
        chk("ot_resume_valid", 32'(wr_valid_o), 32'd1);
        drain();
        wr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) resp(0);
        chk("ot_three_resp_not_empty", 32'(empty_o), 32'd0);
        resp(0);
        chk("ot_four_resp_empty", 32'(empty_o), 32'd1);

        // Error response pulses once
        store(32'h7000, LSU_W, 32'h77777777, mk(32'h7000, 32'h77777777, 4'b1111), 1);
        drain();
        wr_ready_i = 1'b0;
        resp(1);
        chk("err_pulse_hi", 32'(st_err_o), 32'd1);
        step();
        chk("err_pulse_lo", 32'(st_err_o), 32'd0);
        chk("err_empty", 32'(empty_o), 32'd1);

`ifdef STORE_BUF_MISALIGN_CHK_EN
        wr_ready_i = 1'b1;
        store(32'h3001, LSU_W, 32'h12345678, mk(32'h3000, 32'h12345678, 4'b1111), 0);
        chk("mis_pulse_hi", 32'(st_misalign_o), 32'd1);
        chk("mis_no_write", 32'(wr_valid_o), 32'd0);
        step();
        chk("mis_pulse_lo", 32'(st_misalign_o), 32'd0);
        chk("mis_no_write2", 32'(wr_valid_o), 32'd0);
        chk("mis_empty", 32'(empty_o), 32'd1);
        wr_ready_i = 1'b0;
`else
        wr_ready_i = 1'b1;
        store(32'h3001, LSU_W, 32'h11223344, mk(32'h3000, 32'h11223344, 4'b1111), 1);
        chk("nomis_word", 32'(st_misalign_o), 32'd0);
        store(32'h2003, LSU_H, 32'hABCD, mk(32'h2000, 32'hCD000000, 4'b1000), 1);
        chk("nomis_half", 32'(st_misalign_o), 32'd0);
        drain();
        wr_ready_i = 1'b0;
        resp(0);
        resp(0);
        chk("nomis_empty", 32'(empty_o), 32'd1);
`endif

        // Reset with two entries buffered
        store(32'h8000, LSU_W, 32'h80808080, mk(32'h8000, 32'h80808080, 4'b1111), 1);
        store(32'h8004, LSU_W, 32'h81818181, mk(32'h8004, 32'h81818181, 4'b1111), 1);
        chk("pre_rst_full", 32'(st_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        sb.delete();
        @(negedge clk);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_empty", 32'(empty_o), 32'd1);
        chk("post_rst_ready", 32'(st_ready_o), 32'd1);
        chk("post_rst_valid", 32'(wr_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
